// File: rtl/meas_acc_capture_if.sv
// ----------------------------------------------------------------------------
// meas_acc_capture_if
//   Bundles the measurement-result inputs and the capture-buffer write port
//   of meas_acc_capture.
//
//   master : the side that produces start/trig/done/xacc/yacc and observes
//            the buffer write port and status (register map / engines).
//   slave  : the capture block itself.
//
//   start    arm strobe, one cycle
//   trig     period trigger, one cycle
//   done     per-channel result-valid pulse
//   xacc     channel i X result in bits [i*DW +: DW]
//   yacc     channel i Y result, same packing
//   wr_en    buffer write enable
//   wr_addr  {channel, word index}
//   wr_data  buffer write data
//   full     per-channel buffer full
//   overrun  per-channel sticky dropped-result flag
//   running  capture FSM is in RUN
// ----------------------------------------------------------------------------
interface meas_acc_capture_if #(
   parameter int NMEAS = 4,
   parameter int DW    = 32,
   parameter int AW    = 12
);
   localparam int CW = $clog2(NMEAS);

   logic                  start;
   logic                  trig;
   logic [NMEAS-1:0]      done;
   logic [NMEAS*DW-1:0]   xacc;
   logic [NMEAS*DW-1:0]   yacc;
   logic                  wr_en;
   logic [CW+AW-1:0]      wr_addr;
   logic [DW-1:0]         wr_data;
   logic [NMEAS-1:0]      full;
   logic [NMEAS-1:0]      overrun;
   logic                  running;

   modport master (
      output start, trig, done, xacc, yacc,
      input  wr_en, wr_addr, wr_data, full, overrun, running
   );

   modport slave (
      input  start, trig, done, xacc, yacc,
      output wr_en, wr_addr, wr_data, full, overrun, running
   );
endinterface

// File: rtl/meas_acc_capture.sv
// ----------------------------------------------------------------------------
// meas_acc_capture
//   Captures each channel's xacc/yacc result on its done pulse into a
//   per-channel holding register, then writes X (even word) and Y (odd word)
//   into a shared capture buffer through one write port, arbitrated
//   round-robin between channels. Capture is armed by start and begins at the
//   next trig; each channel stops at 2^AW words (full). A result arriving
//   while the channel's holding register is still occupied is dropped and
//   flagged in overrun.
//
//   clk    : dsp clock
//   reset  : asynchronous active-high reset
//   bus    : meas_acc_capture_if.slave (inputs start/trig/done/xacc/yacc,
//            outputs wr_en/wr_addr/wr_data/full/overrun/running)
// ----------------------------------------------------------------------------
module meas_acc_capture #(
   parameter int NMEAS = 4,
   parameter int DW    = 32,
   parameter int AW    = 12
) (
   input  logic clk,
   input  logic reset,
   meas_acc_capture_if.slave bus
);
   localparam int CW  = $clog2(NMEAS);
   localparam int WAW = CW + AW;
   localparam logic [CW:0] NCH      = NMEAS[CW:0];
   localparam logic [AW:0] CNT_STEP = 2;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT_TRIG, ST_RUN, ST_STOP} state_t;

   state_t           state_q, state_d;
   logic             running;

   logic [AW:0]      cnt_q      [NMEAS];
   logic [AW:0]      cnt_d      [NMEAS];
   logic [DW-1:0]    hold_x_q   [NMEAS];
   logic [DW-1:0]    hold_x_d   [NMEAS];
   logic [DW-1:0]    hold_y_q   [NMEAS];
   logic [DW-1:0]    hold_y_d   [NMEAS];
   logic [NMEAS-1:0] hold_valid_q, hold_valid_d;
   logic [NMEAS-1:0] overrun_q, overrun_d;

   // Writer: wr_phase_q=0 means the word currently on the port is X,
   // 1 means it is Y. wr_ch_q is the channel owning the current write.
   logic             wr_en_q, wr_en_d;
   logic             wr_phase_q, wr_phase_d;
   logic [CW-1:0]    wr_ch_q, wr_ch_d;
   logic [CW-1:0]    last_q, last_d;
   logic [WAW-1:0]   wr_addr_q, wr_addr_d;
   logic [DW-1:0]    wr_data_q, wr_data_d;

   logic             in_run, go_run, x_now, y_now;
   logic [NMEAS-1:0] full_vec, y_done, eff_full, capture, drop, req;
   logic [DW-1:0]    x_slice [NMEAS];
   logic [DW-1:0]    y_slice [NMEAS];

   logic             grant_valid;
   logic [CW-1:0]    grant_ch;
   logic [CW:0]      arb_idx;

   // start wins over a simultaneous trig
   assign in_run = (state_q == ST_RUN);
   assign go_run = (state_q == ST_WAIT_TRIG) && bus.trig && !bus.start;
   assign x_now  = wr_en_q && !wr_phase_q;
   assign y_now  = wr_en_q &&  wr_phase_q;

   // ---------------------------------------------------------------------
   // Per-channel capture decisions
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NMEAS; gi++) begin : g_ch
         logic [AW:0] cnt_plus2;

         assign x_slice[gi]  = bus.xacc[gi*DW +: DW];
         assign y_slice[gi]  = bus.yacc[gi*DW +: DW];
         assign cnt_plus2    = cnt_q[gi] + CNT_STEP;
         assign full_vec[gi] = cnt_q[gi][AW];
         // Channel's Y word is on the port this cycle: its hold frees up
         // at this edge and may be reloaded immediately.
         assign y_done[gi]   = y_now && (wr_ch_q == CW'(gi));
         // Fullness as it will be after this edge, so a recapture is never
         // accepted for a result that would land beyond the last word.
         assign eff_full[gi] = y_done[gi] ? cnt_plus2[AW] : cnt_q[gi][AW];
         assign capture[gi]  = in_run && bus.done[gi] && !eff_full[gi] &&
                               (!hold_valid_q[gi] || y_done[gi]);
         assign drop[gi]     = in_run && bus.done[gi] && !eff_full[gi] &&
                               hold_valid_q[gi] && !y_done[gi];
         // The channel finishing its Y is excluded so its (possibly
         // reloaded) hold is not granted before it settles.
         assign req[gi]      = hold_valid_q[gi] && !y_done[gi];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Round-robin arbiter: cyclic search starting after last grant
   // ---------------------------------------------------------------------
   always_comb begin
      grant_valid = 1'b0;
      grant_ch    = '0;
      arb_idx     = '0;
      for (int k = 1; k <= NMEAS; k++) begin
         arb_idx = {1'b0, last_q} + k[CW:0];
         if (arb_idx >= NCH) begin
            arb_idx = arb_idx - NCH;
         end
         if (!grant_valid && req[arb_idx[CW-1:0]]) begin
            grant_valid = 1'b1;
            grant_ch    = arb_idx[CW-1:0];
         end
      end
   end

   // ---------------------------------------------------------------------
   // FSM: state register / next state / outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.start) begin
         state_d = ST_WAIT_TRIG;
      end else begin
         case (state_q)
            ST_WAIT_TRIG: if (bus.trig)  state_d = ST_RUN;
            ST_RUN:       if (&full_vec) state_d = ST_STOP;
            default:      state_d = state_q;
         endcase
      end
   end

   always_comb begin
      running = (state_q == ST_RUN);
   end

   // ---------------------------------------------------------------------
   // Channel state next-value logic
   // ---------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NMEAS; i++) begin
         cnt_d[i]    = cnt_q[i];
         hold_x_d[i] = hold_x_q[i];
         hold_y_d[i] = hold_y_q[i];
      end
      hold_valid_d = hold_valid_q;
      overrun_d    = overrun_q;

      if (bus.start) begin
         hold_valid_d = '0;
      end else if (go_run) begin
         for (int i = 0; i < NMEAS; i++) begin
            cnt_d[i] = '0;
         end
         hold_valid_d = '0;
         overrun_d    = '0;
      end else begin
         overrun_d = overrun_q | drop;
         for (int i = 0; i < NMEAS; i++) begin
            if (y_done[i]) begin
               cnt_d[i]        = cnt_q[i] + CNT_STEP;
               hold_valid_d[i] = 1'b0;
            end
            if (capture[i]) begin
               hold_valid_d[i] = 1'b1;
               hold_x_d[i]     = x_slice[i];
               hold_y_d[i]     = y_slice[i];
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Writer next-value logic
   // ---------------------------------------------------------------------
   always_comb begin
      wr_en_d    = 1'b0;
      wr_phase_d = 1'b0;
      wr_ch_d    = wr_ch_q;
      last_d     = last_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      if (bus.start) begin
         wr_en_d = 1'b0;
      end else if (x_now) begin
         // Counts advance in steps of two, so the Y word is the X address
         // with bit 0 set.
         wr_en_d    = 1'b1;
         wr_phase_d = 1'b1;
         wr_addr_d  = {wr_addr_q[WAW-1:1], 1'b1};
         wr_data_d  = hold_y_q[wr_ch_q];
      end else if (grant_valid) begin
         wr_en_d    = 1'b1;
         wr_phase_d = 1'b0;
         wr_ch_d    = grant_ch;
         last_d     = grant_ch;
         wr_addr_d  = {grant_ch, cnt_q[grant_ch][AW-1:0]};
         wr_data_d  = hold_x_q[grant_ch];
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NMEAS; i++) begin
            cnt_q[i] <= '0;
         end
         hold_valid_q <= '0;
         overrun_q    <= '0;
         wr_en_q      <= 1'b0;
         wr_phase_q   <= 1'b0;
         wr_ch_q      <= '0;
         last_q       <= CW'(NMEAS - 1);
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         for (int i = 0; i < NMEAS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         hold_valid_q <= hold_valid_d;
         overrun_q    <= overrun_d;
         wr_en_q      <= wr_en_d;
         wr_phase_q   <= wr_phase_d;
         wr_ch_q      <= wr_ch_d;
         last_q       <= last_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
      end
   end

   // Hold data is qualified by hold_valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NMEAS; i++) begin
         hold_x_q[i] <= hold_x_d[i];
         hold_y_q[i] <= hold_y_d[i];
      end
   end

   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.full    = full_vec;
   assign bus.overrun = overrun_q;
   assign bus.running = running;

endmodule
